// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared definitions for the complementary PWM gate driver.
// Holds the FSM state labels and the default dead-time counter width.
// Imported by the RTL and by the bench reference model.
package pwm_deadtime_gen_pkg;

   localparam int DT_W_DEF = 8;

   typedef enum logic [2:0] {
      SAFE  = 3'd0,
      DEAD  = 3'd1,
      HI_ON = 3'd2,
      LO_ON = 3'd3,
      FAULT = 3'd4
   } state_e;

endpackage

// File: rtl/pwm_deadtime_gen_dt_counter.sv
// Loadable down-counter for the dead-time interval, zero flag from the register.
// Latency: load/decrement take effect at the next edge; zero is combinational from state.
// Backpressure: none; decrement saturates at zero, never wraps.
module dt_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   // Load takes priority over decrement; decrement holds at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low gate driver with programmable dead time, enable gating and sticky fault.
// Latency: active side drops on the edge that samples the pwm change; opposite side rises D edges later.
// Backpressure: none; outputs are registered and never both high.
module pwm_deadtime_gen
   import pwm_deadtime_gen_pkg::*;
#(
   parameter int DT_W   = DT_W_DEF,
   parameter int MIN_DT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            pwm_in,
   input  logic [DT_W-1:0] dead_cycles,
   input  logic            fault,
   input  logic            fault_clr,
   output logic            hi_out,
   output logic            lo_out,
   output logic            fault_flag,
   output logic            in_dead
);

   localparam logic [DT_W-1:0] MIN_DT_V = DT_W'(MIN_DT);

   state_e          state_q, state_d;
   logic            flag_q, flag_d;
   logic            hi_q, lo_q, dead_q;
   logic            cnt_load, cnt_dec, cnt_zero;
   logic [DT_W-1:0] dt_applied;
   logic [DT_W-1:0] cnt_load_val;

   // Dead time actually applied, floored so there is always at least one low cycle.
   assign dt_applied   = (dead_cycles < MIN_DT_V) ? MIN_DT_V : dead_cycles;
   assign cnt_load_val = dt_applied - DT_W'(1);

   dt_counter #(.W(DT_W)) u_dt_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Next-state: fault beats disable beats normal switching; FAULT only exits through fault_clr.
   always_comb begin
      state_d  = state_q;
      flag_d   = flag_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      if (fault) begin
         state_d = FAULT;
         flag_d  = 1'b1;
      end else if (state_q == FAULT) begin
         if (fault_clr) begin
            flag_d  = 1'b0;
            state_d = SAFE;
         end
      end else if (!en) begin
         state_d = SAFE;
      end else begin
         case (state_q)
            SAFE: begin
               if (!flag_q) begin
                  state_d  = DEAD;
                  cnt_load = 1'b1;
               end
            end
            DEAD: begin
               if (cnt_zero) begin
                  state_d = pwm_in ? HI_ON : LO_ON;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            HI_ON: begin
               if (!pwm_in) begin
                  state_d  = DEAD;
                  cnt_load = 1'b1;
               end
            end
            LO_ON: begin
               if (pwm_in) begin
                  state_d  = DEAD;
                  cnt_load = 1'b1;
               end
            end
            default: state_d = SAFE;
         endcase
      end
   end

   // State, sticky flag and outputs all register together so the pins follow the state exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SAFE;
         flag_q  <= 1'b0;
         hi_q    <= 1'b0;
         lo_q    <= 1'b0;
         dead_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         flag_q  <= flag_d;
         hi_q    <= (state_d == HI_ON);
         lo_q    <= (state_d == LO_ON);
         dead_q  <= (state_d == DEAD);
      end
   end

   assign hi_out     = hi_q;
   assign lo_out     = lo_q;
   assign in_dead    = dead_q;
   assign fault_flag = flag_q;

endmodule
